// File: rtl/data_sram_bridge_pkg.sv
// data_sram_bridge_pkg: shared widths, FSM state encoding and SRAM-like size codes.
package data_sram_bridge_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, HOLD = 2'd3} state_e;
    typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2} size_e;
endpackage

// File: rtl/data_sram_bridge_if.sv
// data_sram_bridge_if: SRAM-like request/response bus between the bridge (master) and memory (slave).
interface data_sram_bridge_if;
    import data_sram_bridge_pkg::*;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );
    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_sram_bridge_mem_size_decode.sv
// mem_size_decode: maps a byte write mask and byte address to SRAM-like wr/size/address.
module mem_size_decode
    import data_sram_bridge_pkg::*;
(
    input  logic [MASK_W-1:0] mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              o_wr,
    output logic [1:0]        o_size,
    output logic [ADDR_W-1:0] o_addr
);
    logic [1:0] w_off;
    // loads and illegal masks fall through to a full aligned word
    always_comb begin
        w_off  = 2'd0;
        o_size = SIZE_W;
        case (mem_wen)
            4'b0001: begin o_size = SIZE_B; w_off = 2'd0; end
            4'b0010: begin o_size = SIZE_B; w_off = 2'd1; end
            4'b0100: begin o_size = SIZE_B; w_off = 2'd2; end
            4'b1000: begin o_size = SIZE_B; w_off = 2'd3; end
            4'b0011: begin o_size = SIZE_H; w_off = 2'd0; end
            4'b1100: begin o_size = SIZE_H; w_off = 2'd2; end
            default: begin o_size = SIZE_W; w_off = 2'd0; end
        endcase
    end
    assign o_wr   = |mem_wen;
    assign o_addr = {mem_addr[ADDR_W-1:2], w_off};
endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns one MEM-stage access into a single SRAM-like transaction and
// stalls the pipeline until it completes; HOLD keeps the result until the pipeline advances.
module data_sram_bridge
    import data_sram_bridge_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_en,
    input  logic [MASK_W-1:0]   mem_wen,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                longest_stall,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                d_stall,
    data_sram_bridge_if.master  bus
);
    state_e            r_state, w_next;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              w_wr, w_idle, w_start, w_done;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;

    mem_size_decode u_dec (
        .mem_wen (mem_wen),
        .mem_addr(mem_addr),
        .o_wr    (w_wr),
        .o_size  (w_size),
        .o_addr  (w_addr)
    );

    assign w_idle  = r_state == IDLE;
    assign w_start = w_idle & mem_en;
    assign w_done  = ((bus.data_req & bus.data_addr_ok) | (r_state == DATA)) & bus.data_data_ok;

    assign bus.data_req   = w_start | (r_state == ADDR);
    assign bus.data_wr    = w_idle ? w_wr : r_wr;
    assign bus.data_size  = w_idle ? w_size : r_size;
    assign bus.data_addr  = w_idle ? w_addr : r_addr;
    assign bus.data_wdata = w_idle ? mem_wdata : r_wdata;
    assign d_stall        = w_start | (r_state == ADDR) | (r_state == DATA);
    assign mem_rdata      = r_rdata;

    // data_ok arriving with addr_ok completes the access in one step
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, ADDR: if (bus.data_req) w_next = bus.data_addr_ok ? (bus.data_data_ok ? HOLD : DATA) : ADDR;
            DATA:       if (bus.data_data_ok) w_next = HOLD;
            HOLD:       if (!longest_stall) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_wr    <= w_wr;
                r_size  <= w_size;
                r_addr  <= w_addr;
                r_wdata <= mem_wdata;
            end
            if (w_done) r_rdata <= bus.data_rdata;
        end
    end
endmodule
